endgame_sequencer: RTL and testbench

Consumes the one-cycle end-of-round pulse produced by the game's delay generator and runs the Dig Dug end-of-round sequence. It freezes play, blinks the Dug sprite on death, and updates the lives and level counters. It then issues a one-cycle restart pulse to the level loader, or latches game-over. It sits between the round-end pulse source and the level/sprite logic, stepping on VGA frame ticks.

---
 rtl/endgame_sequencer.sv | 124 ++++++++++++
 tb/tb_endgame_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/endgame_sequencer.sv
// End-of-round sequencer: freezes play, blinks Dug on death, updates lives/level,
// then pulses restart_level to the level loader or latches game-over.
module endgame_sequencer #(
  parameter int unsigned FREEZE_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES  = 120,
  parameter int unsigned BLINK_PERIOD  = 8,
  parameter int unsigned LIVES         = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       endgame_req,
  input  logic       cause,
  output logic       freeze,
  output logic       busy,
  output logic       sprite_visible,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic       restart_level,
  output logic       game_over
);

  localparam logic [7:0] FREEZE_LAST = 8'(FREEZE_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);
  localparam int unsigned BLINK_BIT  = $clog2(BLINK_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREEZE,
    S_BLINK,
    S_RESTART,
    S_OVER
  } state_t;

  state_t     state, state_nx;
  logic [7:0] count, count_nx;
  logic       cause_r, cause_nx;
  logic [1:0] lives_nx;
  logic [3:0] level_nx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      count   <= '0;
      cause_r <= 1'b0;
      lives   <= 2'(LIVES);
      level   <= 4'd1;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      cause_r <= cause_nx;
      lives   <= lives_nx;
      level   <= level_nx;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_nx = state;
    count_nx = count;
    cause_nx = cause_r;
    lives_nx = lives;
    level_nx = level;
    unique case (state)
      S_IDLE: begin
        if (endgame_req) begin
          state_nx = S_FREEZE;
          cause_nx = cause;
          count_nx = '0;
        end
      end
      S_FREEZE: begin
        if (frame_tick) begin
          if (count == FREEZE_LAST) begin
            count_nx = '0;
            if (cause_r) begin
              state_nx = S_RESTART;
              if (level != 4'd15) level_nx = level + 4'd1;
            end else begin
              state_nx = S_BLINK;
            end
          end else begin
            count_nx = count + 8'd1;
          end
        end
      end
      S_BLINK: begin
        if (frame_tick) begin
          if (count == BLINK_LAST) begin
            count_nx = '0;
            // Last life lost goes straight to OVER without a restart pulse.
            if (lives != 2'd0) lives_nx = lives - 2'd1;
            state_nx = (lives <= 2'd1) ? S_OVER : S_RESTART;
          end else begin
            count_nx = count + 8'd1;
          end
        end
      end
      S_RESTART: begin
        state_nx = S_IDLE;
        count_nx = '0;
      end
      S_OVER:  ;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy          = (state != S_IDLE);
  assign freeze        = busy;
  assign restart_level = (state == S_RESTART);
  assign game_over     = (state == S_OVER);

  always_comb begin
    unique case (state)
      S_OVER:  sprite_visible = 1'b0;
      S_BLINK: sprite_visible = ~count[BLINK_BIT];
      default: sprite_visible = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_endgame_sequencer.sv
// Randomized bench for endgame_sequencer against a tick-counting reference model.
module tb_endgame_sequencer;

  localparam int F = 2;
  localparam int B = 4;
  localparam int P = 2;
  localparam int L = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       endgame_req = 1'b0;
  logic       cause = 1'b0;
  logic       freeze, busy, sprite_visible, restart_level, game_over;
  logic [1:0] lives;
  logic [3:0] level;

  endgame_sequencer #(
    .FREEZE_FRAMES(F),
    .BLINK_FRAMES (B),
    .BLINK_PERIOD (P),
    .LIVES        (L)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .endgame_req   (endgame_req),
    .cause         (cause),
    .freeze        (freeze),
    .busy          (busy),
    .sprite_visible(sprite_visible),
    .lives         (lives),
    .level         (level),
    .restart_level (restart_level),
    .game_over     (game_over)
  );

  always #5 Clk = ~Clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  // Reference model: a sequence is "ticks counted since the request was taken".
  bit m_active, m_cause, m_restart, m_over;
  int m_ticks, m_lives, m_level;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_cause = 0; m_restart = 0; m_over = 0;
    m_ticks = 0; m_lives = L; m_level = 1;
  endtask

  function automatic bit model_in_blink();
    return m_active && !m_restart && !m_over && !m_cause && m_ticks >= F;
  endfunction

  task automatic model_update(input bit rq, input bit cs, input bit tk, input bit rst);
    if (rst) model_reset();
    else if (m_over) ;
    else if (m_restart) begin
      m_restart = 0;
      m_active  = 0;
    end else if (!m_active) begin
      if (rq) begin
        m_active = 1;
        m_cause  = cs;
        m_ticks  = 0;
      end
    end else if (tk) begin
      m_ticks++;
      if (m_cause && m_ticks == F) begin
        m_level   = (m_level < 15) ? m_level + 1 : 15;
        m_restart = 1;
      end else if (!m_cause && m_ticks == F + B) begin
        m_lives--;
        if (m_lives == 0) m_over = 1;
        else m_restart = 1;
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_busy, exp_sprite;
    exp_busy = m_active || m_over;
    if (m_over) exp_sprite = 0;
    else if (model_in_blink()) exp_sprite = (((m_ticks - F) / P) % 2) == 0;
    else exp_sprite = 1;
    check("freeze",         8'(freeze),         8'(exp_busy));
    check("busy",           8'(busy),           8'(exp_busy));
    check("sprite_visible", 8'(sprite_visible), 8'(exp_sprite));
    check("lives",          8'(lives),          8'(m_lives));
    check("level",          8'(level),          8'(m_level));
    check("restart_level",  8'(restart_level),  8'(m_restart));
    check("game_over",      8'(game_over),      8'(m_over));
  endtask

  // One clock: check at the falling edge, drive inputs, let the rising edge sample.
  task automatic step(input bit rq, input bit cs, input bit rst);
    bit tk;
    @(negedge Clk);
    check_outputs();
    tk          = (cyc % 5 == 0);
    Reset       = rst;
    endgame_req = rq;
    cause       = cs;
    frame_tick  = tk;
    @(posedge Clk);
    model_update(rq, cs, tk, rst);
    cyc++;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge Clk);
    step(0, 0, 1);

    // Quiet idle after reset.
    repeat (20) step(0, 0, 0);

    // Level clear, then two deaths to game over, with stray requests mixed in.
    step(1, 1, 0);
    for (int i = 0; i < 30; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    for (int d = 0; d < 2; d++) begin
      while (m_active) step(0, 0, 0);
      step(1, 0, 0);
      for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 3) == 0), 1, 0);
    end
    for (int i = 0; i < 30; i++) step(1, 1'($urandom_range(0, 1)), 0);

    // Long randomized run with occasional resets, biased toward mid-BLINK.
    step(0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      rst = ($urandom_range(0, 299) == 0) ||
            (model_in_blink() && $urandom_range(0, 60) == 0) ||
            (m_over && $urandom_range(0, 30) == 0);
      step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0), rst);
    end

    // Sixteen level clears in a row to exercise level saturation.
    step(0, 0, 1);
    for (int c = 0; c < 16; c++) begin
      for (int g = 0; g < 40 && m_active; g++) step(0, 0, 0);
      step(1, 1, 0);
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    check("level_saturated", 8'(level), 8'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
